// File: rtl/multi_lane_hit_reducer.sv
// rtl/multi_lane_hit_reducer.sv - multi-lane closest/any-hit reducer; optional HIT_REDUCER_STATS_EN adds o_hit_count
module multi_lane_hit_reducer #(
    parameter int                 LANES = 4,
    parameter int                 IDX_W = 32,
    parameter logic signed [31:0] MIN_T = 32'sd0
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_start,
    input  logic [IDX_W-1:0]        i_tri_cnt,
    input  logic                    i_any_hit,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [LANES-1:0]        i_hit,
    input  logic [32*LANES-1:0]     i_t,
    output logic                    o_busy,
    output logic                    o_hit,
    output logic signed [31:0]      o_t,
    output logic [IDX_W-1:0]        o_tri_index,
`ifdef HIT_REDUCER_STATS_EN
    output logic [IDX_W-1:0]        o_hit_count,
`endif
    output logic                    o_finish
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Extra headroom so base + lane never wraps before it is compared with the count.
    localparam int XW = IDX_W + 4;

    logic [1:0]         state;
    logic [XW-1:0]      base;
    logic [IDX_W-1:0]   cnt_q;
    logic               any_q;
    logic               s1_valid;
    logic               s1_hit;
    logic signed [31:0] s1_t;
    logic [IDX_W-1:0]   s1_idx;

    logic               accept;
    logic               last_beat;
    logic               b_found;
    logic signed [31:0] b_t;
    logic [IDX_W-1:0]   b_idx;
    logic [XW-1:0]      lane_idx;
    logic signed [31:0] lane_t;
`ifdef HIT_REDUCER_STATS_EN
    logic [3:0]         b_pop;
    logic [IDX_W:0]     hc_sum;
`endif

    assign o_ready   = (state == S_RUN);
    assign o_busy    = (state == S_RUN) || (state == S_DRAIN);
    assign o_finish  = (state == S_DONE);
    assign accept    = (state == S_RUN) && i_valid;
    assign last_beat = (base + XW'(LANES)) >= {4'b0, cnt_q};

    // Any-hit keeps the first qualifying lane; closest keeps the strictly smaller t.
    always_comb begin
        b_found  = 1'b0;
        b_t      = '0;
        b_idx    = '0;
        lane_idx = '0;
        lane_t   = '0;
`ifdef HIT_REDUCER_STATS_EN
        b_pop    = '0;
`endif
        for (int k = 0; k < LANES; k++) begin
            lane_idx = base + XW'(k);
            lane_t   = i_t[32*k +: 32];
            if (i_hit[k] && (lane_idx < {4'b0, cnt_q}) && (lane_t >= MIN_T)) begin
`ifdef HIT_REDUCER_STATS_EN
                b_pop = b_pop + 4'd1;
`endif
                if (!b_found || (!any_q && (lane_t < b_t))) begin
                    b_found = 1'b1;
                    b_t     = lane_t;
                    b_idx   = lane_idx[IDX_W-1:0];
                end
            end
        end
    end

`ifdef HIT_REDUCER_STATS_EN
    assign hc_sum = {1'b0, o_hit_count} + (IDX_W+1)'(b_pop);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state       <= S_IDLE;
            base        <= '0;
            cnt_q       <= '0;
            any_q       <= 1'b0;
            s1_valid    <= 1'b0;
            s1_hit      <= 1'b0;
            s1_t        <= '0;
            s1_idx      <= '0;
            o_hit       <= 1'b0;
            o_t         <= 32'sh7fffffff;
            o_tri_index <= '0;
`ifdef HIT_REDUCER_STATS_EN
            o_hit_count <= '0;
`endif
        end else if (i_start && (state != S_DONE)) begin
            state       <= (i_tri_cnt == '0) ? S_DONE : S_RUN;
            base        <= '0;
            cnt_q       <= i_tri_cnt;
            any_q       <= i_any_hit;
            s1_valid    <= 1'b0;
            o_hit       <= 1'b0;
            o_t         <= 32'sh7fffffff;
            o_tri_index <= '0;
`ifdef HIT_REDUCER_STATS_EN
            o_hit_count <= '0;
`endif
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_hit <= b_found;
                s1_t   <= b_t;
                s1_idx <= b_idx;
                base   <= base + XW'(LANES);
`ifdef HIT_REDUCER_STATS_EN
                o_hit_count <= hc_sum[IDX_W] ? '1 : hc_sum[IDX_W-1:0];
`endif
            end
            // Equal t never replaces: earlier beats always hold lower indices.
            if (s1_valid && s1_hit && (!o_hit || (s1_t < o_t))) begin
                o_hit       <= 1'b1;
                o_t         <= s1_t;
                o_tri_index <= s1_idx;
            end
            case (state)
                S_RUN:   if (accept && (last_beat || (any_q && b_found))) state <= S_DRAIN;
                S_DRAIN: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_lane_hit_reducer.sv
// tb/tb_multi_lane_hit_reducer.sv - randomized and directed bench for multi_lane_hit_reducer
module tb_multi_lane_hit_reducer;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_start;
    logic [31:0] i_tri_cnt;
    logic        i_any_hit;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_hit;
    logic [127:0] i_t;
    logic        o_busy;
    logic        o_hit;
    logic [31:0] o_t;
    logic [31:0] o_tri_index;
    logic        o_finish;
`ifdef HIT_REDUCER_STATS_EN
    logic [31:0] o_hit_count;
`endif

    multi_lane_hit_reducer dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_tri_cnt(i_tri_cnt),
        .i_any_hit(i_any_hit), .i_valid(i_valid), .o_ready(o_ready), .i_hit(i_hit),
        .i_t(i_t), .o_busy(o_busy), .o_hit(o_hit), .o_t(o_t), .o_tri_index(o_tri_index),
`ifdef HIT_REDUCER_STATS_EN
        .o_hit_count(o_hit_count),
`endif
        .o_finish(o_finish)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int fin_cnt = 0;

    logic [3:0]  bh [16];
    logic [31:0] bt [16][4];

    always @(negedge i_clk) if (o_finish) fin_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick_t();
        case ($urandom_range(0, 4))
            0: return 32'(-$urandom_range(1, 100));
            1: return 32'h0;
            2: return 32'($urandom_range(1, 3)) << 16;
            3: return $urandom & 32'h7ffffff0;
            default: return 32'($urandom_range(0, 100));
        endcase
    endfunction

    task automatic clear_beats();
        for (int b = 0; b < 16; b++) begin
            bh[b] = 4'h0;
            for (int k = 0; k < 4; k++) bt[b][k] = 32'h0;
        end
    endtask

    task automatic fill_random();
        for (int b = 0; b < 16; b++) begin
            bh[b] = 4'($urandom & $urandom);
            for (int k = 0; k < 4; k++) bt[b][k] = pick_t();
        end
    endtask

    // Reference: walk triangles in index order, apply the qualify and selection rules directly.
    task automatic model(input int cnt, input bit any, output bit eh, output logic [31:0] et,
                         output int eidx, output int ebeats, output int ecount);
        int nb;
        bit beat_q;
        eh = 0; et = 32'h7fffffff; eidx = 0; ecount = 0;
        nb = (cnt + 3) / 4;
        ebeats = nb;
        for (int b = 0; b < nb; b++) begin
            beat_q = 0;
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = b * 4 + k;
                if (idx < cnt && bh[b][k] && $signed(bt[b][k]) >= 0) begin
                    ecount++;
                    beat_q = 1;
                    if (!eh || (!any && $signed(bt[b][k]) < $signed(et))) begin
                        eh = 1; et = bt[b][k]; eidx = idx;
                    end
                end
            end
            if (any && beat_q) begin
                ebeats = b + 1;
                break;
            end
        end
    endtask

    task automatic start_batch(input int cnt, input bit any);
        i_start = 1; i_tri_cnt = cnt; i_any_hit = any;
        @(posedge i_clk); #1;
        i_start = 0;
    endtask

    task automatic send_beat(input int b);
        i_valid = 1;
        i_hit = bh[b];
        for (int k = 0; k < 4; k++) i_t[32*k +: 32] = bt[b][k];
        @(posedge i_clk); #1;
        i_valid = 0;
    endtask

    task automatic run_batch(input int cnt, input bit any, input string tag);
        bit eh;
        logic [31:0] et;
        int eidx, ebeats, ecount, nb, sent, lat, f0;
        model(cnt, any, eh, et, eidx, ebeats, ecount);
        nb = (cnt + 3) / 4;
        f0 = fin_cnt;
        start_batch(cnt, any);
        sent = 0;
        for (int b = 0; b < nb; b++) begin
            if (!o_ready) break;
            send_beat(b);
            sent++;
            if (o_ready && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge i_clk) #1;
        end
        check({tag, "_beats"}, sent, ebeats);
        if (cnt > 0) begin
            check({tag, "_ready_lo"}, o_ready, 0);
            check({tag, "_busy"}, o_busy, 1);
        end
        // A winning beat presented outside RUN must be ignored.
        i_valid = 1; i_hit = 4'hf; i_t = '0;
        lat = 0;
        while (!o_finish && lat < 8) begin
            @(posedge i_clk); #1;
            lat++;
        end
        check({tag, "_fin_lat"}, lat, (cnt > 0) ? 1 : 0);
        check({tag, "_hit"}, o_hit, eh);
        check({tag, "_t"}, o_t, et);
        check({tag, "_idx"}, o_tri_index, eidx);
`ifdef HIT_REDUCER_STATS_EN
        check({tag, "_hcnt"}, o_hit_count, ecount);
`endif
        @(posedge i_clk); #1;
        i_valid = 0;
        check({tag, "_fin_lo"}, o_finish, 0);
        check({tag, "_fin_cnt"}, fin_cnt - f0, 1);
    endtask

    initial begin
        i_rstn = 0; i_start = 0; i_tri_cnt = 0; i_any_hit = 0; i_valid = 0; i_hit = 0; i_t = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ready", o_ready, 0);
        check("rst_busy", o_busy, 0);
        check("rst_finish", o_finish, 0);
        check("rst_hit", o_hit, 0);
        check("rst_t", o_t, 32'h7fffffff);
        check("rst_idx", o_tri_index, 0);
        i_rstn = 1;
        @(posedge i_clk); #1;

        clear_beats();
        bh[0] = 4'b0010; bt[0][1] = 32'h0003_0000;
        bh[1] = 4'b1111; bt[1][0] = 32'h0001_0000; bt[1][1] = 32'h0002_0000;
        run_batch(6, 0, "closest6");
        check("closest6_idx4", o_tri_index, 4);
        check("closest6_t", o_t, 32'h0001_0000);
`ifdef HIT_REDUCER_STATS_EN
        check("closest6_hcnt3", o_hit_count, 3);
`endif

        run_batch(0, 0, "zero");
        check("zero_t", o_t, 32'h7fffffff);

        clear_beats();
        bt[0][0] = 32'h0000_0001;
        bh[1] = 4'b1100; bt[1][2] = 32'h0005_0000; bt[1][3] = 32'h0001_0000;
        bh[2] = 4'b1111;
        run_batch(12, 1, "anyhit");
        check("anyhit_idx6", o_tri_index, 6);

        clear_beats();
        bh[0] = 4'b0011; bt[0][0] = 32'hffff_ffff; bt[0][1] = 32'h0002_0000;
        bh[1] = 4'b0010; bt[1][1] = 32'h0002_0000;
        run_batch(8, 0, "tie");
        check("tie_idx1", o_tri_index, 1);

        begin : abort_test
            int f0;
            f0 = fin_cnt;
            clear_beats();
            bh[0] = 4'b0001; bh[1] = 4'b0001;
            start_batch(12, 0);
            send_beat(0);
            send_beat(1);
            fill_random();
            bh[0][0] = 1'b1; bt[0][0] = 32'h0004_0000;
            run_batch(4, 0, "abort");
            check("abort_one_finish", fin_cnt - f0, 1);
        end

        begin : reset_drain
            int f0;
            clear_beats();
            bh[0] = 4'b0001; bt[0][0] = 32'h0001_0000;
            f0 = fin_cnt;
            start_batch(4, 0);
            send_beat(0);
            check("rd_busy", o_busy, 1);
            i_rstn = 0;
            @(posedge i_clk); #1;
            check("rd_ready", o_ready, 0);
            check("rd_busy0", o_busy, 0);
            check("rd_finish", o_finish, 0);
            check("rd_hit", o_hit, 0);
            check("rd_t", o_t, 32'h7fffffff);
            check("rd_idx", o_tri_index, 0);
            i_rstn = 1;
            repeat (4) @(posedge i_clk);
            #1;
            check("rd_no_finish", fin_cnt - f0, 0);
        end

        for (int n = 0; n < 40; n++) begin
            fill_random();
            run_batch($urandom_range(0, 40), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
